fib_checker: RTL and testbench

Receive-side checker for the 6-bit Fibonacci counter stream. Samples the counter value on a one-cycle valid strobe, locks onto the sequence start (0 then 1), tracks the expected next term, and flags every deviation. Sits on the system clock downstream of the divided-clock Fibonacci counter; the strobe marks each counter advance.

---
 rtl/fib_pkg.sv | 21 ++
 rtl/fib_term_lut.sv | 17 +
 rtl/fib_checker.sv | 118 +++++++++++
 tb/tb_fib_checker.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/fib_pkg.sv
// rtl/fib_pkg.sv - shared Fibonacci stream constants, term table and checker state encoding
package fib_pkg;

  localparam int FIB_W   = 6;
  localparam int FIB_LEN = 11;
  localparam int IDX_W   = 4;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FIB_LEN - 1);

  // 89 does not fit in FIB_W bits, so the producer wraps after 55
  localparam logic [FIB_W-1:0] FIB_TERMS [FIB_LEN] = '{
    6'd0, 6'd1, 6'd1, 6'd2, 6'd3, 6'd5, 6'd8, 6'd13, 6'd21, 6'd34, 6'd55
  };

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ARMED  = 2'd1,
    LOCKED = 2'd2
  } fib_state_e;

endpackage

// File: rtl/fib_term_lut.sv
// rtl/fib_term_lut.sv - combinational sequence index to Fibonacci term lookup
// Indices past the end of the table return 0.
module fib_term_lut
  import fib_pkg::*;
(
  input  logic [IDX_W-1:0] i_idx,
  output logic [FIB_W-1:0] o_term
);

  always_comb begin
    o_term = '0;
    if (i_idx <= IDX_LAST) begin
      o_term = FIB_TERMS[i_idx];
    end
  end

endmodule

// File: rtl/fib_checker.sv
// rtl/fib_checker.sv - receive-side lock/track checker for the 6-bit Fibonacci counter stream
// FIBCHK_ERRCNT_EN builds the saturating mismatch counter; otherwise err_count is tied to 0.
module fib_checker
  import fib_pkg::*;
#(
  parameter int MATCH_W = 8,
  parameter int ERR_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [FIB_W-1:0]   in_data,
  input  logic               in_valid,
  output logic               locked,
  output logic               err,
  output logic [IDX_W-1:0]   index,
  output logic [MATCH_W-1:0] match_count,
  output logic [ERR_W-1:0]   err_count
);

  fib_state_e         r_state;
  fib_state_e         w_state_nxt;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   w_idx_nxt;
  logic [IDX_W-1:0]   w_idx_succ;
  logic [FIB_W-1:0]   w_exp_term;
  logic [MATCH_W-1:0] r_match;
  logic [MATCH_W-1:0] w_match_nxt;
  logic               r_err;
  logic               w_err_nxt;

  // Tracking by index rather than by value disambiguates the repeated 1
  assign w_idx_succ = (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);

  fib_term_lut u_term_lut (
    .i_idx  (w_idx_succ),
    .o_term (w_exp_term)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_match_nxt = r_match;
    w_err_nxt   = 1'b0;
    if (in_valid) begin
      case (r_state)
        SEARCH: begin
          if (in_data == '0) begin
            w_state_nxt = ARMED;
          end
        end
        ARMED: begin
          if (in_data == FIB_W'(1)) begin
            w_state_nxt = LOCKED;
            w_idx_nxt   = IDX_W'(1);
            w_match_nxt = '0;
          end else if (in_data != '0) begin
            w_state_nxt = SEARCH;
          end
        end
        LOCKED: begin
          if (in_data == w_exp_term) begin
            w_idx_nxt = w_idx_succ;
            if (r_match != '1) begin
              w_match_nxt = r_match + MATCH_W'(1);
            end
          end else begin
            w_err_nxt   = 1'b1;
            w_match_nxt = '0;
            w_idx_nxt   = '0;
            // A mismatching 0 may itself be the start of a fresh sequence
            w_state_nxt = (in_data == '0) ? ARMED : SEARCH;
          end
        end
        default: begin
          w_state_nxt = SEARCH;
          w_idx_nxt   = '0;
          w_match_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= SEARCH;
      r_idx   <= '0;
      r_match <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_match <= w_match_nxt;
      r_err   <= w_err_nxt;
    end
  end

`ifdef FIBCHK_ERRCNT_EN
  logic [ERR_W-1:0] r_err_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err_cnt <= '0;
    end else if (w_err_nxt && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + ERR_W'(1);
    end
  end

  assign err_count = r_err_cnt;
`else
  assign err_count = '0;
`endif

  assign locked      = (r_state == LOCKED);
  assign err         = r_err;
  assign index       = r_idx;
  assign match_count = r_match;

endmodule

// File: tb/tb_fib_checker.sv
// tb/tb_fib_checker.sv - directed, table-driven self-checking bench for fib_checker
// Honours FIBCHK_ERRCNT_EN for the expected err_count values.
module tb_fib_checker;

  logic       clk;
  logic       rst;
  logic [5:0] in_data;
  logic       in_valid;
  logic       locked;
  logic       err;
  logic [3:0] index;
  logic [7:0] match_count;
  logic [7:0] err_count;

  int n_cmp;
  int n_fail;

  typedef struct {
    logic       v;
    logic [5:0] d;
    logic       lk;
    logic       er;
    logic [3:0] ix;
    logic [7:0] mc;
  } vec_t;

  vec_t vecs[$];
  logic [5:0] fib_ref [11];

  fib_checker #(.MATCH_W(8), .ERR_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .locked      (locked),
    .err         (err),
    .index       (index),
    .match_count (match_count),
    .err_count   (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int lk, input int er, input int ix, input int mc);
    check({tag, ".locked"}, int'(locked), lk);
    check({tag, ".err"}, int'(err), er);
    check({tag, ".index"}, int'(index), ix);
    check({tag, ".match_count"}, int'(match_count), mc);
  endtask

  task automatic apply(input logic v, input logic [5:0] d);
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic add_vec(input logic v, input logic [5:0] d, input logic lk,
                         input logic er, input logic [3:0] ix, input logic [7:0] mc);
    vec_t t;
    t.v = v; t.d = d; t.lk = lk; t.er = er; t.ix = ix; t.mc = mc;
    vecs.push_back(t);
  endtask

  initial begin
    int cur;
    int mc;
    int pulses;
    int spurious;
    int exp_ec;

    n_cmp = 0;
    n_fail = 0;
    fib_ref = '{6'd0, 6'd1, 6'd1, 6'd2, 6'd3, 6'd5, 6'd8, 6'd13, 6'd21, 6'd34, 6'd55};

    //       v     d      lk    er    ix     mc
    add_vec(1'b1, 6'd0,  1'b0, 1'b0, 4'd0, 8'd0);
    add_vec(1'b1, 6'd1,  1'b1, 1'b0, 4'd1, 8'd0);
    add_vec(1'b1, 6'd1,  1'b1, 1'b0, 4'd2, 8'd1);
    add_vec(1'b1, 6'd2,  1'b1, 1'b0, 4'd3, 8'd2);
    add_vec(1'b1, 6'd3,  1'b1, 1'b0, 4'd4, 8'd3);
    add_vec(1'b1, 6'd5,  1'b1, 1'b0, 4'd5, 8'd4);
    add_vec(1'b1, 6'd8,  1'b1, 1'b0, 4'd6, 8'd5);
    add_vec(1'b1, 6'd14, 1'b0, 1'b1, 4'd0, 8'd0);
    add_vec(1'b0, 6'd0,  1'b0, 1'b0, 4'd0, 8'd0);
    add_vec(1'b1, 6'd1,  1'b0, 1'b0, 4'd0, 8'd0);
    add_vec(1'b1, 6'd0,  1'b0, 1'b0, 4'd0, 8'd0);
    add_vec(1'b1, 6'd0,  1'b0, 1'b0, 4'd0, 8'd0);
    add_vec(1'b1, 6'd1,  1'b1, 1'b0, 4'd1, 8'd0);
    add_vec(1'b1, 6'd1,  1'b1, 1'b0, 4'd2, 8'd1);
    add_vec(1'b1, 6'd0,  1'b0, 1'b1, 4'd0, 8'd0);
    add_vec(1'b1, 6'd1,  1'b1, 1'b0, 4'd1, 8'd0);
    add_vec(1'b1, 6'd7,  1'b0, 1'b1, 4'd0, 8'd0);
    add_vec(1'b1, 6'd0,  1'b0, 1'b0, 4'd0, 8'd0);
    add_vec(1'b1, 6'd5,  1'b0, 1'b0, 4'd0, 8'd0);
    add_vec(1'b1, 6'd1,  1'b0, 1'b0, 4'd0, 8'd0);

    rst = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all("reset", 0, 0, 0, 0);
    check("reset.err_count", int'(err_count), 0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      apply(vecs[i].v, vecs[i].d);
      check_all($sformatf("row%0d", i), int'(vecs[i].lk), int'(vecs[i].er),
                int'(vecs[i].ix), int'(vecs[i].mc));
    end
`ifdef FIBCHK_ERRCNT_EN
    check("table.err_count", int'(err_count), 3);
`else
    check("table.err_count", int'(err_count), 0);
`endif

    for (int k = 0; k < 11; k++) begin
      apply(1'b1, fib_ref[k]);
      check_all($sformatf("run%0d", k), (k >= 1) ? 1 : 0, 0, k, (k >= 2) ? k - 1 : 0);
    end
    apply(1'b1, 6'd0);
    check_all("wrap0", 1, 0, 0, 10);
    apply(1'b1, 6'd1);
    check_all("wrap1", 1, 0, 1, 11);
    apply(1'b1, 6'd1);
    check_all("wrap2", 1, 0, 2, 12);

    for (int c = 0; c < 20; c++) begin
      apply(1'b0, 6'($urandom_range(63)));
      check_all($sformatf("idle%0d", c), 1, 0, 2, 12);
    end

    cur = 2;
    mc = 12;
    for (int s = 0; s < 300; s++) begin
      cur = (cur + 1) % 11;
      mc = (mc < 255) ? mc + 1 : 255;
      apply(1'b1, fib_ref[cur]);
      check_all($sformatf("sat%0d", s), 1, 0, cur, mc);
    end
    check("sat.final_match", int'(match_count), 255);
    check("sat.final_index", int'(index), 5);

    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_all("async_rst", 0, 0, 0, 0);
    check("async_rst.err_count", int'(err_count), 0);
    @(negedge clk);
    rst = 1'b1;

    apply(1'b1, 6'd0);
    apply(1'b1, 6'd1);
    check_all("relock", 1, 0, 1, 0);
    pulses = 0;
    spurious = 0;
    for (int m = 0; m < 300; m++) begin
      apply(1'b1, 6'd0);
      if (err && !locked) pulses++;
      apply(1'b1, 6'd1);
      if (err || !locked) spurious++;
    end
    check("force.err_pulses", pulses, 300);
    check("force.spurious", spurious, 0);
`ifdef FIBCHK_ERRCNT_EN
    exp_ec = 255;
`else
    exp_ec = 0;
`endif
    check("force.err_count", int'(err_count), exp_ec);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
